// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port DataMemory.
// Optional lock feature: define DMEM_ARB_LOCK_EN to add lock0/lock1 inputs.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  // Handshake: reqN is a valid command that must stay stable until gntN is
  // high in the same cycle; gntN is combinational, the command transfers at
  // that rising edge, and the requester may change its command afterwards.
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          memRead,
  output logic          memWrite,
  output logic [AW-1:0] address,
  output logic [DW-1:0] writeData,
  input  logic [DW-1:0] readData,
  output logic [0:0]    dbg_state,
  output logic          dbg_rr
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]    state;
  logic          rr;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_id;

  logic          g0;
  logic          g1;
  logic          any_gnt;
  logic          locked;
  logic          lock_owner;
  logic          access;

`ifdef DMEM_ARB_LOCK_EN
  logic last_vld;
  logic last_id;

  // Lock follows whoever was granted last, even across idle cycles.
  assign locked     = last_vld && (last_id ? lock1 : lock0);
  assign lock_owner = last_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_vld <= 1'b0;
      last_id  <= 1'b0;
    end else if (any_gnt) begin
      last_vld <= 1'b1;
      last_id  <= g1;
    end
  end
`else
  assign locked     = 1'b0;
  assign lock_owner = 1'b0;
`endif

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end else if (locked) begin
      g0 = !lock_owner && req0;
      g1 = lock_owner && req1;
    end else if (req0 && req1) begin
      g0 = !rr;
      g1 = rr;
    end else begin
      g0 = req0;
      g1 = req1;
    end
  end

  assign any_gnt = g0 || g1;
  assign gnt0    = g0;
  assign gnt1    = g1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_id    <= 1'b0;
    end else if (any_gnt) begin
      state     <= ACCESS;
      cmd_we    <= g1 ? we1 : we0;
      cmd_addr  <= g1 ? addr1 : addr0;
      cmd_wdata <= g1 ? wdata1 : wdata0;
      cmd_id    <= g1;
      // Favour the requester that just lost; frozen while a lock is held.
      if (!locked) rr <= g0;
    end else begin
      state <= IDLE;
    end
  end

  // Load data is captured at the closing edge of its ACCESS cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata   <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= (state == ACCESS) && !cmd_we && !cmd_id;
      rvalid1 <= (state == ACCESS) && !cmd_we && cmd_id;
      if ((state == ACCESS) && !cmd_we) rdata <= readData;
    end
  end

  assign access    = (state == ACCESS) && !rst;
  assign memRead   = access && !cmd_we;
  assign memWrite  = access && cmd_we;
  assign address   = access ? cmd_addr : '0;
  assign writeData = access ? cmd_wdata : '0;

  assign dbg_state = state;
  assign dbg_rr    = rr;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-cycle vector table plus a read-data scoreboard.
// Lock scenario is included when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          memRead, memWrite;
  logic [AW-1:0] address;
  logic [DW-1:0] writeData, readData;
  logic [0:0]    dbg_state;
  logic          dbg_rr;
`ifdef DMEM_ARB_LOCK_EN
  logic          lock0 = 1'b0, lock1 = 1'b0;
`endif

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
`ifdef DMEM_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .memRead(memRead), .memWrite(memWrite), .address(address),
    .writeData(writeData), .readData(readData),
    .dbg_state(dbg_state), .dbg_rr(dbg_rr)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  logic run_mon = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] seed(input int i);
    logic [7:0] b;
    b = i[7:0];
    return (i == 16) ? 32'hDEADBEEF : {b, ~b, b, 8'h5A};
  endfunction

  // memory model behind the DUT
  logic [DW-1:0] mem [0:255];
  assign readData = mem[address[7:0]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed(i);
    end else if (memWrite) begin
      mem[address[7:0]] <= writeData;
    end
  end

  // scoreboard
  logic [DW-1:0] exp_mem [0:255];
  logic [DW-1:0] exp_q[$];
  logic          id_q[$];
  int            due_q[$];

  logic          em_rd = 1'b0, em_wr = 1'b0;
  logic [AW-1:0] em_addr = '0;
  logic [DW-1:0] em_wd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run_mon && !rst) begin
      if (exp_q.size() > 0 && due_q[0] == cyc) begin
        check("rvalid_owner", {62'd0, rvalid1, rvalid0}, id_q[0] ? 64'd2 : 64'd1);
        check("rdata", {32'd0, rdata}, {32'd0, exp_q[0]});
        void'(exp_q.pop_front());
        void'(id_q.pop_front());
        void'(due_q.pop_front());
      end else begin
        check("no_rvalid", {62'd0, rvalid1, rvalid0}, 64'd0);
      end
    end
  end

  task automatic flush_model();
    exp_q.delete();
    id_q.delete();
    due_q.delete();
    for (int i = 0; i < 256; i++) exp_mem[i] = seed(i);
    em_rd = 1'b0; em_wr = 1'b0; em_addr = '0; em_wd = '0;
  endtask

  // driver tasks
  typedef struct {
    logic          rst_first;
    logic          r0, w0, r1, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          l0;
    logic          eg0, eg1;
  } vec_t;

  function automatic vec_t mk(input logic rf, input logic r0, input logic w0,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input logic r1, input logic w1,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic eg0, input logic eg1, input logic l0);
    vec_t v;
    v.rst_first = rf;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.l0 = l0;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    flush_model();
    @(negedge clk);
    check("rst_gnt", {62'd0, gnt1, gnt0}, 64'd0);
    check("rst_mem_ctl", {62'd0, memRead, memWrite}, 64'd0);
    check("rst_state", {63'd0, dbg_state}, 64'd0);
    check("rst_rr", {63'd0, dbg_rr}, 64'd0);
    check("rst_rvalid", {62'd0, rvalid1, rvalid0}, 64'd0);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_mon = 1'b1;
  endtask

  task automatic step(input vec_t v);
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (v.rst_first) do_reset();
    @(posedge clk);
    #1;
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
`ifdef DMEM_ARB_LOCK_EN
    lock0 = v.l0;
`endif
    @(negedge clk);
    check("gnt", {62'd0, gnt1, gnt0}, {62'd0, v.eg1, v.eg0});
    check("mem_ctl", {62'd0, memRead, memWrite}, {62'd0, em_rd, em_wr});
    check("mem_addr", {32'd0, address}, {32'd0, em_addr});
    check("mem_wdata", {32'd0, writeData}, {32'd0, em_wd});
    if (v.eg0 || v.eg1) begin
      we = v.eg1 ? v.w1 : v.w0;
      a  = v.eg1 ? v.a1 : v.a0;
      d  = v.eg1 ? v.d1 : v.d0;
      em_rd = !we; em_wr = we; em_addr = a; em_wd = d;
      if (we) begin
        exp_mem[a[7:0]] = d;
      end else begin
        exp_q.push_back(exp_mem[a[7:0]]);
        id_q.push_back(v.eg1);
        due_q.push_back(cyc + 2);
      end
    end else begin
      em_rd = 1'b0; em_wr = 1'b0; em_addr = '0; em_wd = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [DW-1:0] rnd;
    rnd = {$urandom_range(16'hFFFF, 0), $urandom_range(16'hFFFF, 0)};

    // single load after reset: gnt0, then ACCESS, then rvalid0 with 0xDEADBEEF
    tbl.push_back(mk(1, 1, 0, 'h10, 'h0, 0, 0, 'h0, 'h0, 1, 0, 0));
    tbl.push_back(idle());
    tbl.push_back(idle());
    // both requesting from reset: 0,1,0,1 then leftover req0
    tbl.push_back(mk(1, 1, 0, 'h30, 'h1, 1, 0, 'h34, 'h2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 'h38, 'h3, 1, 0, 'h34, 'h2, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 'h38, 'h3, 1, 0, 'h3C, 'h4, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 'h30, 'h5, 1, 0, 'h3C, 'h4, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 'h30, 'h5, 0, 0, 'h0, 'h0, 1, 0, 0));
    tbl.push_back(idle());
    tbl.push_back(idle());
    // req1 store then load back-to-back
    tbl.push_back(mk(0, 0, 0, 'h0, 'h0, 1, 1, 'h20, 'h12345678, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 'h0, 'h0, 1, 0, 'h20, 'h0, 0, 1, 0));
    tbl.push_back(idle());
    tbl.push_back(idle());
    // mixed contention with a random store value
    tbl.push_back(mk(0, 1, 1, 'h40, rnd, 1, 0, 'h10, 'h0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 'h40, 'h0, 1, 0, 'h10, 'h0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 'h40, 'h0, 0, 0, 'h0, 'h0, 1, 0, 0));
    tbl.push_back(idle());
    tbl.push_back(idle());

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // reset during the ACCESS cycle of a load
    step(mk(1, 1, 0, 'h10, 'h0, 0, 0, 'h0, 'h0, 1, 0, 0));
    @(posedge clk);
    #1;
    check("acc_memRead", {63'd0, memRead}, 64'd1);
    check("acc_rr", {63'd0, dbg_rr}, 64'd1);
    rst = 1'b1;
    flush_model();
    #1;
    check("rst_memRead", {63'd0, memRead}, 64'd0);
    check("rst_gnt_hold", {62'd0, gnt1, gnt0}, 64'd0);
    check("rst_rr_mid", {63'd0, dbg_rr}, 64'd0);
    check("rst_state_mid", {63'd0, dbg_state}, 64'd0);
    req0 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(idle());

`ifdef DMEM_ARB_LOCK_EN
    // lock0 held for 3 cycles keeps requester 0 granted
    step(mk(1, 1, 0, 'h10, 'h0, 1, 0, 'h30, 'h0, 1, 0, 1));
    step(mk(0, 1, 0, 'h10, 'h0, 1, 0, 'h30, 'h0, 1, 0, 1));
    step(mk(0, 1, 0, 'h10, 'h0, 1, 0, 'h30, 'h0, 1, 0, 1));
    step(mk(0, 1, 0, 'h10, 'h0, 1, 0, 'h30, 'h0, 0, 1, 0));
    for (int i = 0; i < 3; i++) step(idle());
`endif

    check("sb_empty", exp_q.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
